// File: rtl/code_matcher_4slot.sv
// Scans the four 16-bit password slots for the entered code and reports match/slot.
// Also tracks consecutive failed attempts and enforces a timed lockout after too many.
module code_matcher_4slot #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] code,
    output logic [1:0]  mem_idx,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [1:0]  match_idx,
    output logic        locked,
    output logic [3:0]  fail_count
);

    localparam int TW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SET,
        CMP,
        RESULT
    } state_t;

    state_t        state_q;
    logic [15:0]   code_q;
    logic [1:0]    k_q;
    logic [1:0]    mem_idx_q;
    logic          mem_enable_q;
    logic          busy_q;
    logic          done_q;
    logic          match_q;
    logic [1:0]    match_idx_q;
    logic          locked_q;
    logic [3:0]    fail_count_q;
    logic [TW-1:0] timer_q;

    logic          hit_d;
    logic [3:0]    fail_count_d;

    // An all-zero slot is empty, so a zero code can never unlock anything.
    assign hit_d = (mem_rdata == code_q) && (mem_rdata != 16'h0000);

    always_comb begin
        fail_count_d = fail_count_q;
        if (fail_count_q < 4'(MAX_FAILS)) begin
            fail_count_d = fail_count_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            code_q       <= 16'h0000;
            k_q          <= 2'd0;
            mem_idx_q    <= 2'd0;
            mem_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            match_idx_q  <= 2'd0;
            locked_q     <= 1'b0;
            fail_count_q <= 4'd0;
            timer_q      <= '0;
        end else begin
            done_q <= 1'b0;

            // Lockout expiry also forgives the accumulated failures.
            if (locked_q) begin
                if (timer_q == TW'(1)) begin
                    locked_q     <= 1'b0;
                    timer_q      <= '0;
                    fail_count_q <= 4'd0;
                end else begin
                    timer_q <= timer_q - TW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start && !locked_q) begin
                        code_q       <= code;
                        k_q          <= 2'd0;
                        mem_idx_q    <= 2'd0;
                        mem_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        match_q      <= 1'b0;
                        state_q      <= SET;
                    end
                end
                SET: begin
                    state_q <= CMP;
                end
                CMP: begin
                    if (hit_d) begin
                        match_q      <= 1'b1;
                        match_idx_q  <= k_q;
                        fail_count_q <= 4'd0;
                        done_q       <= 1'b1;
                        mem_enable_q <= 1'b0;
                        state_q      <= RESULT;
                    end else if (k_q == 2'd3) begin
                        match_q      <= 1'b0;
                        fail_count_q <= fail_count_d;
                        if (fail_count_d == 4'(MAX_FAILS)) begin
                            locked_q <= 1'b1;
                            timer_q  <= TW'(LOCK_CYCLES);
                        end
                        done_q       <= 1'b1;
                        mem_enable_q <= 1'b0;
                        state_q      <= RESULT;
                    end else begin
                        k_q       <= k_q + 2'd1;
                        mem_idx_q <= k_q + 2'd1;
                        state_q   <= SET;
                    end
                end
                RESULT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_idx    = mem_idx_q;
    assign mem_enable = mem_enable_q;
    assign mem_wr     = 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign match      = match_q;
    assign match_idx  = match_idx_q;
    assign locked     = locked_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_code_matcher_4slot.sv
// Directed bench for code_matcher_4slot: a vector table of single checks followed by
// hand-written sequences for lockout, held start, code change and mid-scan reset.
module tb_code_matcher_4slot;

    logic              clk;
    logic              reset;
    logic              start;
    logic [15:0]       code;
    logic [1:0]        mem_idx;
    logic              mem_enable;
    logic              mem_wr;
    logic [15:0]       mem_rdata;
    logic              busy;
    logic              done;
    logic              match;
    logic [1:0]        match_idx;
    logic              locked;
    logic [3:0]        fail_count;

    logic [3:0][15:0]  mem;
    int                testCount;
    int                failCount;
    logic              wrSeen;

    typedef struct {
        logic [3:0][15:0] memw;
        logic [15:0]      code;
        logic             expMatch;
        logic [1:0]       expIdx;
        int               expLat;
        logic [3:0]       expFail;
        logic             expLocked;
    } vec_t;

    localparam logic [3:0][15:0] MEM_A    = {16'h6002, 16'h00C3, 16'h0035, 16'h0021};
    localparam logic [3:0][15:0] MEM_ZERO = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [3:0][15:0] MEM_DUP  = {16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
    localparam logic [3:0][15:0] MEM_E0   = {16'h3333, 16'h2222, 16'h1111, 16'h0000};

    vec_t vecs [11];

    code_matcher_4slot #(
        .MAX_FAILS  (3),
        .LOCK_CYCLES(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .code      (code),
        .mem_idx   (mem_idx),
        .mem_enable(mem_enable),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .match     (match),
        .match_idx (match_idx),
        .locked    (locked),
        .fail_count(fail_count)
    );

    // Combinational-read memory model.
    assign mem_rdata = mem[mem_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr !== 1'b0) wrSeen = 1'b1;
    end

    function automatic vec_t mkVec(input logic [3:0][15:0] m, input logic [15:0] c,
                                   input logic em, input logic [1:0] ei, input int el,
                                   input logic [3:0] ef, input logic elk);
        vec_t v;
        v.memw      = m;
        v.code      = c;
        v.expMatch  = em;
        v.expIdx    = ei;
        v.expLat    = el;
        v.expFail   = ef;
        v.expLocked = elk;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One complete check: start on a clean IDLE cycle, then watch the scan until done.
    task automatic applyStimulus(input vec_t v);
        int lat;
        int bad;
        @(negedge clk);
        checkOutput("idleBusy", {31'd0, busy}, 32'd0);
        mem   = v.memw;
        code  = v.code;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (lat < 0) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    lat = c;
                end else if (mem_enable !== 1'b1 || busy !== 1'b1 || mem_idx !== 2'(c / 2)) begin
                    bad++;
                end
            end
        end
        checkOutput("latency", lat, v.expLat);
        checkOutput("scanSeq", bad, 32'd0);
        checkOutput("match", {31'd0, match}, {31'd0, v.expMatch});
        if (v.expMatch) checkOutput("matchIdx", {30'd0, match_idx}, {30'd0, v.expIdx});
        checkOutput("failCount", {28'd0, fail_count}, {28'd0, v.expFail});
        checkOutput("locked", {31'd0, locked}, {31'd0, v.expLocked});
    endtask

    initial begin
        int cnt;
        int dones;
        logic busySeen;

        testCount = 0;
        failCount = 0;
        wrSeen    = 1'b0;
        reset     = 1'b1;
        start     = 1'b1;
        code      = 16'h0021;
        mem       = MEM_A;

        vecs[0]  = mkVec(MEM_A,    16'h00C3, 1'b1, 2'd2, 6, 4'd0, 1'b0);
        vecs[1]  = mkVec(MEM_A,    16'h0021, 1'b1, 2'd0, 2, 4'd0, 1'b0);
        vecs[2]  = mkVec(MEM_A,    16'h0035, 1'b1, 2'd1, 4, 4'd0, 1'b0);
        vecs[3]  = mkVec(MEM_A,    16'h6002, 1'b1, 2'd3, 8, 4'd0, 1'b0);
        vecs[4]  = mkVec(MEM_ZERO, 16'h0000, 1'b0, 2'd0, 8, 4'd1, 1'b0);
        vecs[5]  = mkVec(MEM_A,    16'h1234, 1'b0, 2'd0, 8, 4'd2, 1'b0);
        vecs[6]  = mkVec(MEM_A,    16'h0021, 1'b1, 2'd0, 2, 4'd0, 1'b0);
        vecs[7]  = mkVec(MEM_DUP,  16'hBEEF, 1'b1, 2'd1, 4, 4'd0, 1'b0);
        vecs[8]  = mkVec(MEM_A,    16'h0000, 1'b0, 2'd0, 8, 4'd1, 1'b0);
        vecs[9]  = mkVec(MEM_E0,   16'h0000, 1'b0, 2'd0, 8, 4'd2, 1'b0);
        vecs[10] = mkVec(MEM_A,    16'h0035, 1'b1, 2'd1, 4, 4'd0, 1'b0);

        // Reset held two cycles with start high.
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checkOutput("rstDone", dones, 32'd0);
        checkOutput("rstOutputs",
                    {17'd0, mem_idx, mem_enable, mem_wr, busy, done, match, match_idx, locked, fail_count},
                    32'd0);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Three misses trigger lockout with the third done.
        applyStimulus(mkVec(MEM_A, 16'hAAAA, 1'b0, 2'd0, 8, 4'd1, 1'b0));
        applyStimulus(mkVec(MEM_A, 16'hBBBB, 1'b0, 2'd0, 8, 4'd2, 1'b0));
        applyStimulus(mkVec(MEM_A, 16'hCCCC, 1'b0, 2'd0, 8, 4'd3, 1'b1));
        cnt      = 0;
        busySeen = 1'b0;
        code     = 16'h0021;
        while (locked === 1'b1 && cnt < 40) begin
            cnt++;
            start = (cnt <= 4);
            @(negedge clk);
            if (busy === 1'b1) busySeen = 1'b1;
        end
        start = 1'b0;
        checkOutput("lockCycles", cnt, 32'd10);
        checkOutput("lockBusy", {31'd0, busySeen}, 32'd0);
        checkOutput("lockFailClr", {28'd0, fail_count}, 32'd0);
        applyStimulus(mkVec(MEM_A, 16'h0021, 1'b1, 2'd0, 2, 4'd0, 1'b0));

        // Start held through the scan and code changed after acceptance.
        @(negedge clk);
        mem   = MEM_A;
        code  = 16'h6002;
        start = 1'b1;
        @(posedge clk);
        #1 code = 16'h0021;
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("heldStartDones", dones, 32'd1);
        checkOutput("heldStartMatch", {31'd0, match}, 32'd1);
        checkOutput("heldStartIdx", {30'd0, match_idx}, 32'd3);

        // Reset during the compare of slot 1.
        @(negedge clk);
        code  = 16'h6002;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        checkOutput("midScanIdx", {29'd0, mem_enable, mem_idx}, {29'd0, 1'b1, 2'd1});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortState", {29'd0, busy, done, mem_enable}, 32'd0);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checkOutput("abortNoDone", dones, 32'd0);
        checkOutput("memWrNever", {31'd0, wrSeen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
